imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time writer for the processor's instruction memory. It accepts a framed byte stream (typically from a UART receiver), assembles little-endian 32-bit words and writes them sequentially into instruction memory through a dedicated write port. It holds the core in reset until a complete, checksum-verified image has been loaded, then releases it. It sits beside the top-level core, between the byte source and the instruction memory write port.

## Interface
- DEPTH_WORDS, 256: instruction memory capacity in 32-bit words; larger images are rejected.
- BASE_ADDR, 32'h0000_0000: byte address of the first word written.

- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  byte source has a byte on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte; a transfer occurs when in_valid && in_ready at a rising edge.
- imem_we  out  1  one-cycle write strobe to instruction memory.
- imem_addr  out  32  byte address of the write, always word-aligned.
- imem_wdata  out  32  word to write.
- core_rst  out  1  reset to the core; held high until the load completes.
- done  out  1  image loaded and verified; sticky until rst.
- error  out  1  length or checksum fault; sticky until rst.

## Operation
- Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N payload bytes (each word little-endian), then one checksum byte.
- Checksum: XOR of every preceding byte of the frame, including both length bytes.
- States:
  - S_LEN_LO: capture the low length byte, then go to S_LEN_HI.
  - S_LEN_HI: capture the high length byte.
    - If N > DEPTH_WORDS, go to S_ERR.
    - Else if N == 0, go to S_CSUM.
    - Else go to S_DATA.
  - S_DATA: shift bytes into the word register; the byte index counts 0..3.
    - On the 4th byte, issue a write and increment the word counter.
    - After word N-1 is written, go to S_CSUM.
  - S_CSUM: compare the received byte with the running XOR. Match goes to S_DONE; mismatch goes to S_ERR.
  - S_DONE and S_ERR are terminal; only rst leaves them.
- in_ready = 1 in S_LEN_LO, S_LEN_HI, S_DATA and S_CSUM; 0 in S_DONE and S_ERR.
- Write addressing: word k is written at imem_addr = BASE_ADDR + 4*k. Address arithmetic is 32-bit.
- The word counter is wide enough to hold DEPTH_WORDS.
- core_rst = 1 in every state except S_DONE. The core is never released on error.

## Timing
- Reset values: state S_LEN_LO, in_ready 1, imem_we 0, imem_addr BASE_ADDR, imem_wdata 0, core_rst 1, done 0, error 0. The running XOR and all counters are 0.
- Back-to-back bytes (one per cycle) are supported with no stall. Gaps in in_valid are tolerated at any position.
- imem_we is registered: it is high for exactly one cycle, in the cycle after the 4th byte of a word is accepted. imem_addr and imem_wdata are valid in that same cycle.
- done and error rise in the cycle after the deciding byte is accepted. The deciding byte is the checksum byte, or LEN_HI for an oversize length.
- core_rst falls in the same cycle done rises, so the first core fetch follows the last write by at least two cycles.
- in_ready drops in the same cycle done or error rises. Bytes presented after that are ignored.
- Reset mid-frame: on the next edge, return to the full reset state.
  - Any pending write strobe is cancelled.
  - Words already written are not undone.
  - A new frame starts from LEN_LO.
- rst has priority over a simultaneous byte acceptance.

## Test plan
- Good image: stream 02 00 13 00 00 00 EF BE AD DE 33, one byte per cycle.
  - Required: writes of 0x00000013 at 0x0 and 0xDEADBEEF at 0x4, one strobe each.
  - Then done=1, core_rst=0, error=0, in_ready=0.
- Bad checksum: same stream but the last byte is 34.
  - Required: both writes occur, then error=1, done=0, core_rst stays 1, in_ready=0.
- Empty image: 00 00 00.
  - Required: no imem_we, done=1 the cycle after the third byte, core_rst=0.
- Oversize (DEPTH_WORDS=256): 01 01.
  - Required: error=1 the cycle after 01 (LEN_HI) is accepted, no writes, and further in_valid bytes are ignored.
- Gappy source: the good-image stream with in_valid low for 3 cycles between each byte.
  - Required: identical writes and final state.
  - Each strobe lasts one cycle and appears the cycle after the word's 4th byte.
- Reset mid-frame: send 02 00 13 00 00 00 EF, assert rst for one cycle, then send the full good image.
  - Required: exactly three writes in total (0x0 before the reset, then 0x0 and 0x4 after it), then done=1.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
interface imem_loader_if;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;

  logic              in_valid;
  logic [BYTE_W-1:0] in_data;
  logic              in_ready;
  logic              imem_we;
  logic [WORD_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_wdata;

  // Byte source / memory observer side.
  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

  // Loader side: consumes bytes, drives the write port.
  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: parses a length/payload/checksum byte
// frame, writes little-endian words sequentially and releases the core only
// after the image checksum has been verified.
module imem_loader #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.slave  bus,
  output logic          core_rst,
  output logic          done,
  output logic          error
);

  localparam int unsigned CNT_W = $clog2(DEPTH_WORDS + 1);

  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t           state;
  logic [7:0]       len_lo;
  logic [15:0]      len;
  logic [1:0]       byte_idx;
  logic [CNT_W-1:0] word_cnt;
  logic [23:0]      word_buf;
  logic [7:0]       csum;

  logic             accept;
  logic [15:0]      len_rx;
  logic             len_oversize;
  logic             last_word;

  // Byte transfer qualifier and length/word-count decode.
  assign accept       = bus.in_valid && bus.in_ready;
  assign len_rx       = {bus.in_data, len_lo};
  assign len_oversize = 32'(len_rx) > 32'(DEPTH_WORDS);
  assign last_word    = (32'(word_cnt) + 32'd1) == 32'(len);

  // Frame parser, word assembly, write strobe and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_LEN_LO;
      len_lo         <= 8'h00;
      len            <= 16'h0000;
      byte_idx       <= 2'd0;
      word_cnt       <= '0;
      word_buf       <= 24'h00_0000;
      csum           <= 8'h00;
      bus.in_ready   <= 1'b1;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= BASE_ADDR;
      bus.imem_wdata <= 32'h0000_0000;
      core_rst       <= 1'b1;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      bus.imem_we <= 1'b0;
      if (accept) begin
        csum <= csum ^ bus.in_data;
        case (state)
          S_LEN_LO: begin
            len_lo <= bus.in_data;
            state  <= S_LEN_HI;
          end
          S_LEN_HI: begin
            len <= len_rx;
            if (len_oversize) begin
              state        <= S_ERR;
              error        <= 1'b1;
              bus.in_ready <= 1'b0;
            end else if (len_rx == 16'h0000) begin
              state <= S_CSUM;
            end else begin
              state <= S_DATA;
            end
          end
          S_DATA: begin
            // Bytes arrive LSB first; shift right so byte 0 ends at [7:0].
            word_buf <= {bus.in_data, word_buf[23:8]};
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              bus.imem_we    <= 1'b1;
              bus.imem_addr  <= BASE_ADDR + 32'({word_cnt, 2'b00});
              bus.imem_wdata <= {bus.in_data, word_buf};
              word_cnt       <= word_cnt + CNT_W'(1);
              if (last_word) begin
                state <= S_CSUM;
              end
            end
          end
          S_CSUM: begin
            bus.in_ready <= 1'b0;
            if (bus.in_data == csum) begin
              state    <= S_DONE;
              done     <= 1'b1;
              core_rst <= 1'b0;
            end else begin
              state <= S_ERR;
              error <= 1'b1;
            end
          end
          default: begin
            state <= state;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames from the test plan
// plus randomized frames, checked cycle by cycle against a frame-position model.
module tb_imem_loader;

  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic core_rst;
  logic done;
  logic error;

  always #5 clk = ~clk;

  imem_loader_if bus ();

  imem_loader #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .core_rst (core_rst),
    .done     (done),
    .error    (error)
  );

  int tests  = 0;
  int fails  = 0;
  int writes = 0;

  // Count write strobes seen anywhere in the run.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) writes++;
  end

  // Reference model: position within the frame drives everything.
  int          pos;
  int          n;
  logic [7:0]  lo;
  logic [7:0]  x;
  int          status;      // 0 loading, 1 done, 2 error
  logic [31:0] wacc;
  logic        exp_we;
  logic [31:0] exp_addr;
  logic [31:0] exp_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    pos = 0; n = 0; lo = 8'h00; x = 8'h00; status = 0; wacc = 32'h0;
    exp_we = 1'b0; exp_addr = BASE; exp_wdata = 32'h0;
  endtask

  task automatic model_accept(input logic [7:0] b);
    int k;
    if (pos == 0) begin
      lo = b;
    end else if (pos == 1) begin
      n = int'({b, lo});
      if (n > int'(DEPTH)) status = 2;
    end else if (pos < 2 + 4 * n) begin
      k = pos - 2;
      wacc[8 * (k % 4) +: 8] = b;
      if (k % 4 == 3) begin
        exp_we    = 1'b1;
        exp_addr  = BASE + 32'(4 * (k / 4));
        exp_wdata = wacc;
      end
    end else begin
      status = (b == x) ? 1 : 2;
    end
    x = x ^ b;
    pos++;
  endtask

  task automatic check_outputs(input string ctx);
    check({ctx, ".we"},       32'(bus.imem_we),  32'(exp_we));
    check({ctx, ".addr"},     bus.imem_addr,     exp_addr);
    check({ctx, ".wdata"},    bus.imem_wdata,    exp_wdata);
    check({ctx, ".in_ready"}, 32'(bus.in_ready), 32'(status == 0));
    check({ctx, ".done"},     32'(done),         32'(status == 1));
    check({ctx, ".error"},    32'(error),        32'(status == 2));
    check({ctx, ".core_rst"}, 32'(core_rst),     32'(status != 1));
  endtask

  // One clock cycle with the given input; model advances on acceptance.
  task automatic step(input string ctx, input bit v, input logic [7:0] d);
    bit acc;
    bus.in_valid = v;
    bus.in_data  = d;
    acc = v && (status == 0);
    @(posedge clk);
    exp_we = 1'b0;
    if (acc) model_accept(d);
    #1;
    check_outputs(ctx);
  endtask

  // Reset for one edge, optionally with a byte offered at the same edge.
  task automatic do_reset(input string ctx, input bit v, input logic [7:0] d);
    bus.in_valid = v;
    bus.in_data  = d;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    model_reset();
    check_outputs(ctx);
  endtask

  task automatic send(input string ctx, input logic [7:0] q[$], input int gap);
    foreach (q[i]) begin
      for (int g = 0; g < gap; g++) step(ctx, 1'b0, 8'($urandom));
      step(ctx, 1'b1, q[i]);
    end
  endtask

  logic [7:0] good[$] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                          8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h33};
  logic [7:0] bad[$]  = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                          8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h34};
  logic [7:0] empty[$] = '{8'h00, 8'h00, 8'h00};
  logic [7:0] over[$]  = '{8'h01, 8'h01};
  logic [7:0] part[$]  = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hEF};
  logic [7:0] pre3[$]  = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00};
  logic [7:0] frm[$];

  initial begin
    int w0;
    int nw;
    int gap;
    logic [7:0] cs;
    logic [7:0] b;

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    model_reset();

    // Reset state
    do_reset("reset", 1'b0, 8'h00);

    // Good image, back to back, then extra bytes that must be ignored
    w0 = writes;
    send("good", good, 0);
    step("good_tail", 1'b1, 8'h55);
    step("good_tail", 1'b1, 8'hAA);
    check("good.writes", 32'(writes - w0), 32'd2);
    check("good.done", 32'(done), 32'd1);

    // Bad checksum
    do_reset("reset", 1'b0, 8'h00);
    w0 = writes;
    send("badcs", bad, 0);
    step("badcs_tail", 1'b0, 8'h00);
    check("badcs.writes", 32'(writes - w0), 32'd2);
    check("badcs.error", 32'(error), 32'd1);

    // Empty image
    do_reset("reset", 1'b0, 8'h00);
    w0 = writes;
    send("empty", empty, 0);
    check("empty.writes", 32'(writes - w0), 32'd0);

    // Oversize length
    do_reset("reset", 1'b0, 8'h00);
    w0 = writes;
    send("over", over, 0);
    for (int i = 0; i < 6; i++) step("over_tail", 1'b1, 8'(i));
    check("over.writes", 32'(writes - w0), 32'd0);
    check("over.error", 32'(error), 32'd1);

    // Gappy source
    do_reset("reset", 1'b0, 8'h00);
    w0 = writes;
    send("gappy", good, 3);
    check("gappy.writes", 32'(writes - w0), 32'd2);

    // Reset mid-frame, then a full image
    do_reset("reset", 1'b0, 8'h00);
    w0 = writes;
    send("midrst", part, 0);
    do_reset("midrst_rst", 1'b0, 8'h00);
    send("midrst2", good, 0);
    check("midrst.writes", 32'(writes - w0), 32'd3);
    check("midrst.done", 32'(done), 32'd1);

    // Reset coinciding with a word's 4th byte cancels that write
    do_reset("reset", 1'b0, 8'h00);
    w0 = writes;
    send("rstprio", pre3, 0);
    do_reset("rstprio_rst", 1'b1, 8'h00);
    step("rstprio_idle", 1'b0, 8'h00);
    check("rstprio.writes", 32'(writes - w0), 32'd0);

    // Randomized frames
    for (int it = 0; it < 30; it++) begin
      do_reset("reset", 1'b0, 8'h00);
      frm = {};
      if ($urandom_range(0, 7) == 0) nw = 257 + int'($urandom_range(0, 400));
      else if ($urandom_range(0, 9) == 0) nw = 256;
      else nw = int'($urandom_range(0, 5));
      frm.push_back(8'(nw));
      frm.push_back(8'(nw >> 8));
      if (nw <= int'(DEPTH)) begin
        for (int i = 0; i < 4 * nw; i++) frm.push_back(8'($urandom));
        cs = 8'h00;
        foreach (frm[i]) cs = cs ^ frm[i];
        if ($urandom_range(0, 3) == 0) cs = cs ^ 8'($urandom_range(1, 255));
        frm.push_back(cs);
      end
      gap = (nw > 8) ? 0 : int'($urandom_range(0, 2));
      foreach (frm[i]) begin
        if (gap != 0 && $urandom_range(0, 1) == 1) step("rand_gap", 1'b0, 8'($urandom));
        step("rand", 1'b1, frm[i]);
      end
      for (int i = 0; i < 3; i++) begin
        b = 8'($urandom);
        step("rand_tail", 1'($urandom_range(0, 1)), b);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
